fg_cfg_writer: RTL and testbench

FG_CFG_WRITER -- requirements
Module: fg_cfg_writer

---
 rtl/fg_cfg_writer_if.sv | 44 ++++
 rtl/fg_cfg_writer.sv | 230 +++++++++++++++++++++++
 tb/tb_fg_cfg_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fg_cfg_writer_if.sv
// rtl/fg_cfg_writer_if.sv - request and register-file write signals for fg_cfg_writer
//
// Signals:
//   start_i  : request to load a full configuration (requester -> writer)
//   cfg_i    : 64-bit configuration image, CR0 in [63:56] .. CR7 in [7:0]
//   data_o   : register data presented to the register file
//   addr_o   : register address 0..7
//   wr_en_o  : write enable, resynchronized by the receiving register file
//   busy_o   : high while a sequence is in progress
//   done_o   : one-cycle pulse when a sequence completes
//
// Modports:
//   master : the writer block (fg_cfg_writer)
//   slave  : the requester / register-file side

interface fg_cfg_writer_if;
    logic        start_i;
    logic [63:0] cfg_i;
    logic [7:0]  data_o;
    logic [2:0]  addr_o;
    logic        wr_en_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        input  start_i,
        input  cfg_i,
        output data_o,
        output addr_o,
        output wr_en_o,
        output busy_o,
        output done_o
    );

    modport slave (
        output start_i,
        output cfg_i,
        input  data_o,
        input  addr_o,
        input  wr_en_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/fg_cfg_writer.sv
// rtl/fg_cfg_writer.sv - writes an 8-byte configuration image into a resynchronizing register file
//
// Ports:
//   clk_i   : single clock, all flops rising-edge
//   rstn_i  : asynchronous active-low reset
//   bus     : fg_cfg_writer_if.master (start_i, cfg_i in; data_o, addr_o,
//             wr_en_o, busy_o, done_o out)
//
// Parameters:
//   HOLD_CYCLES : cycles wr_en_o is held high per register write
//   GAP_CYCLES  : cycles wr_en_o is low after each strobe, addr/data held
//   SYNC_STAGES : synchronizer depth at the receiver, only used to check
//                 that GAP_CYCLES keeps data stable past the synchronized enable
//
// Optional feature (macro FG_CFG_SKIP_UNCHANGED_EN):
//   Keeps a shadow copy of the bytes last written plus per-byte valid bits and
//   skips any byte whose shadow already matches the image. Skipping costs no
//   cycles: the next byte needing a write is found combinationally.
//
// Every output is a flop so the enable seen by the asynchronous receiver is
// glitch-free; outputs are computed from the next state.

module fg_cfg_writer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    fg_cfg_writer_if.master bus
);

    // The data must stay stable until the enable has crossed every
    // synchronizer stage at the receiver and been sampled once more.
    generate
        if (HOLD_CYCLES < 1 || GAP_CYCLES < SYNC_STAGES + 1) begin : g_bad_params
            $error("fg_cfg_writer: need HOLD_CYCLES>=1 and GAP_CYCLES>=SYNC_STAGES+1");
        end
    endgenerate

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       image_q, image_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Image the next-byte search looks at: the incoming image while idle
    // (it is being latched on this edge), the latched image otherwise.
    logic [63:0]       sel_img;
    logic [7:0]        need;
    logic [3:0]        search_from;
    logic [3:0]        next_pick;
    logic              next_found;
    logic [2:0]        next_idx;

    // CR0 sits in the top byte.
    function automatic logic [7:0] byte_of(input logic [63:0] img, input logic [2:0] i);
        return img[8*(7 - int'(i)) +: 8];
    endfunction

    // Lowest byte index >= from whose need bit is set; 8 means none left.
    function automatic logic [3:0] pick_next(input logic [7:0] nd, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (i >= int'(from) && nd[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    assign sel_img     = (state_q == ST_IDLE) ? bus.cfg_i : image_q;
    assign search_from = (state_q == ST_IDLE) ? 4'd0 : ({1'b0, idx_q} + 4'd1);
    assign next_pick   = pick_next(need, search_from);
    assign next_found  = ~next_pick[3];
    assign next_idx    = next_pick[2:0];

`ifdef FG_CFG_SKIP_UNCHANGED_EN
    logic [63:0] shadow_q, shadow_d;
    logic [7:0]  valid_q, valid_d;

    always_comb begin
        need = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (valid_q[i] && (shadow_q[8*(7-i) +: 8] == byte_of(sel_img, 3'(i)))) begin
                need[i] = 1'b0;
            end
        end
    end
`else
    assign need = 8'hFF;
`endif

    always_comb begin
        state_d = state_q;
        image_d = image_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef FG_CFG_SKIP_UNCHANGED_EN
        shadow_d = shadow_q;
        valid_d  = valid_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    image_d = bus.cfg_i;
                    idx_d   = 3'd0;
                    if (next_found) begin
                        state_d = ST_SETUP;
                        idx_d   = next_idx;
                        addr_d  = next_idx;
                        data_d  = byte_of(bus.cfg_i, next_idx);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = HOLD_LOAD;
            end

            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
`ifdef FG_CFG_SKIP_UNCHANGED_EN
                    shadow_d[8*(7 - int'(idx_q)) +: 8] = byte_of(image_q, idx_q);
                    valid_d[idx_q]                     = 1'b1;
`endif
                    if (next_found) begin
                        state_d = ST_SETUP;
                        idx_d   = next_idx;
                        addr_d  = next_idx;
                        data_d  = byte_of(image_q, next_idx);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_en_d = (state_d == ST_STROBE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            image_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            image_q <= image_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef FG_CFG_SKIP_UNCHANGED_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_q <= '0;
            valid_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
        end
    end
`endif

    assign bus.data_o  = data_q;
    assign bus.addr_o  = addr_q;
    assign bus.wr_en_o = wr_en_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_fg_cfg_writer.sv
// tb/tb_fg_cfg_writer.sv - directed self-checking bench for fg_cfg_writer

module tb_fg_cfg_writer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fg_cfg_writer_if bus ();

    fg_cfg_writer #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Receiver: 2-stage synchronizer, captures while the synchronized enable is high.
    logic       sync1 = 1'b0;
    logic       sync2 = 1'b0;
    logic [7:0] rx_regs [8];
    logic       wr_prev = 1'b0;
    int         strobes = 0;
    int         dones   = 0;
    logic [2:0] last_strobe_addr = 3'd0;

    always @(posedge clk) begin
        sync1   <= bus.wr_en_o;
        sync2   <= sync1;
        wr_prev <= bus.wr_en_o;
        if (sync2) rx_regs[bus.addr_o] <= bus.data_o;
        if (bus.wr_en_o && !wr_prev) begin
            strobes          <= strobes + 1;
            last_strobe_addr <= bus.addr_o;
        end
        if (bus.done_o) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full 73-cycle trace of one sequence; start_i must be 1 on entry (IDLE).
    task automatic run_trace(input logic [63:0] img, input bit hold_start, input logic [63:0] mid_cfg);
        int k, p;
        logic       e_wr, e_done;
        logic [2:0] e_addr;
        logic [7:0] e_data;
        for (int n = 1; n <= 73; n++) begin
            tick();
            if (n == 1 && !hold_start) bus.start_i = 1'b0;
            if (n == 20) bus.cfg_i = mid_cfg;
            if (n <= 72) begin
                k      = (n - 1) / 9;
                p      = (n - 1) % 9;
                e_wr   = (p >= 1 && p <= 4);
                e_addr = 3'(k);
                e_data = img[8*(7-k) +: 8];
                e_done = 1'b0;
            end else begin
                e_wr   = 1'b0;
                e_addr = 3'd7;
                e_data = img[7:0];
                e_done = 1'b1;
            end
            chk($sformatf("c%0d wr_en", n), 64'(bus.wr_en_o), 64'(e_wr));
            chk($sformatf("c%0d addr", n),  64'(bus.addr_o),  64'(e_addr));
            chk($sformatf("c%0d data", n),  64'(bus.data_o),  64'(e_data));
            chk($sformatf("c%0d busy", n),  64'(bus.busy_o),  64'd1);
            chk($sformatf("c%0d done", n),  64'(bus.done_o),  64'(e_done));
        end
    endtask

    task automatic chk_rx(input string tag, input logic [63:0] img);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = img[8*(7-i) +: 8];
            chk($sformatf("%s rx%0d", tag, i), 64'(rx_regs[i]), 64'(b));
        end
    endtask

    logic [63:0] img_a, img_b, img_m, img_c, img_d, img_e;
    int          s_base, d_base, done_n;
    bit          seen;

    initial begin
        img_a = 64'h0011223344556677;
        img_b = 64'hF0E1D2C3B4A59687;
        img_m = 64'h5A5A5A5A5A5A5A5A;
        img_c = 64'h0123456789ABCDEF;
        img_d = 64'h8877665544332211;
        img_e = 64'h8877665544CC2211;

        rstn        = 1'b0;
        bus.start_i = 1'b0;
        bus.cfg_i   = '0;
        #12;
        chk("rst wr_en", 64'(bus.wr_en_o), 64'd0);
        chk("rst busy",  64'(bus.busy_o),  64'd0);
        chk("rst done",  64'(bus.done_o),  64'd0);
        chk("rst addr",  64'(bus.addr_o),  64'd0);
        chk("rst data",  64'(bus.data_o),  64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("idle busy", 64'(bus.busy_o), 64'd0);

        // Basic sequence with the reference image.
        s_base = strobes;
        d_base = dones;
        bus.cfg_i   = img_a;
        bus.start_i = 1'b1;
        run_trace(img_a, 1'b0, img_a);
        tick();
        chk("A idle busy",  64'(bus.busy_o),  64'd0);
        chk("A idle done",  64'(bus.done_o),  64'd0);
        chk("A idle wr_en", 64'(bus.wr_en_o), 64'd0);
        chk("A idle addr",  64'(bus.addr_o),  64'd7);
        chk("A idle data",  64'(bus.data_o),  64'h77);
        chk("A strobes",    64'(strobes - s_base), 64'd8);
        chk("A dones",      64'(dones - d_base),   64'd1);
        chk_rx("A", img_a);

        // start_i held throughout; cfg_i changed mid-sequence.
        s_base = strobes;
        d_base = dones;
        bus.cfg_i   = img_b;
        bus.start_i = 1'b1;
        run_trace(img_b, 1'b1, img_m);
        tick();
        chk("B done ignores start", 64'(bus.busy_o), 64'd0);
        chk("B dones", 64'(dones - d_base), 64'd1);
        chk_rx("B", img_b);
        tick();
        chk("M restart busy",  64'(bus.busy_o),  64'd1);
        chk("M restart addr",  64'(bus.addr_o),  64'd0);
        chk("M restart data",  64'(bus.data_o),  64'h5A);
        chk("M restart wr_en", 64'(bus.wr_en_o), 64'd0);
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (bus.done_o) seen = 1'b1;
        end
        chk("M done seen", 64'(seen), 64'd1);
        tick();
        chk("M strobes", 64'(strobes - s_base), 64'd16);
        chk_rx("M", img_m);

        // Reset while strobing addr 3.
        bus.cfg_i   = img_c;
        bus.start_i = 1'b1;
        for (int n = 1; n <= 29; n++) begin
            tick();
            if (n == 1) bus.start_i = 1'b0;
        end
        chk("C pre-rst wr_en", 64'(bus.wr_en_o), 64'd1);
        chk("C pre-rst addr",  64'(bus.addr_o),  64'd3);
        d_base = dones;
        #2;
        rstn = 1'b0;
        #1;
        chk("async rst wr_en", 64'(bus.wr_en_o), 64'd0);
        chk("async rst busy",  64'(bus.busy_o),  64'd0);
        chk("async rst done",  64'(bus.done_o),  64'd0);
        chk("async rst addr",  64'(bus.addr_o),  64'd0);
        chk("async rst data",  64'(bus.data_o),  64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("C aborted no done", 64'(dones - d_base), 64'd0);
        chk("C idle busy",       64'(bus.busy_o),     64'd0);

        bus.cfg_i   = img_d;
        bus.start_i = 1'b1;
        run_trace(img_d, 1'b0, img_d);
        tick();
        chk_rx("D", img_d);

`ifdef FG_CFG_SKIP_UNCHANGED_EN
        // Only CR5 differs from the shadow.
        s_base = strobes;
        done_n = 0;
        bus.cfg_i   = img_e;
        bus.start_i = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 1) bus.start_i = 1'b0;
            if (bus.done_o && done_n == 0) done_n = n;
        end
        chk("E done cycle",   64'(done_n), 64'd10);
        chk("E strobes",      64'(strobes - s_base), 64'd1);
        chk("E strobe addr",  64'(last_strobe_addr), 64'd5);
        chk("E rx5",          64'(rx_regs[5]), 64'hCC);

        // Same image again: nothing to write.
        s_base = strobes;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("E2 done next cycle", 64'(bus.done_o), 64'd1);
        tick();
        tick();
        chk("E2 strobes", 64'(strobes - s_base), 64'd0);
        chk("E2 idle",    64'(bus.busy_o),       64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
